// File: rtl/led_pattern_engine_if.sv
// Board-side control and LED drive bundle for led_pattern_engine.
// The master drives mode/enable; the slave (engine) drives the LED bank and status pulses.
interface led_pattern_engine_if #(
   parameter int unsigned N = 8
);
   logic         en;
   logic [1:0]   mode;
   logic [N-1:0] led;
   logic         step;
   logic         wrap;

   modport master (output en, mode, input led, step, wrap);
   modport slave  (input en, mode, output led, step, wrap);
endinterface

// File: rtl/led_pattern_engine.sv
// N-LED sequencer: chase, fill bar and bounce animations advanced once per DIV enabled clocks.
// Every mode change passes through one blank step before the new pattern starts.
module led_pattern_engine #(
   parameter int unsigned N   = 8,
   parameter int unsigned DIV = 1
) (
   input logic                 ck,
   input logic                 rs,
   led_pattern_engine_if.slave bus
);
   localparam int unsigned   CW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned   PW       = $clog2(N);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [PW-1:0] POS_LAST = PW'(N - 1);

   typedef enum logic {BLANK, RUN} state_t;
   typedef enum logic [1:0] {M_OFF = 2'b00, M_CHASE = 2'b01, M_FILL = 2'b10, M_BOUNCE = 2'b11} mode_t;

   state_t        state, nxt_state;
   mode_t         cur_mode, nxt_mode, req;
   logic [PW-1:0] pos, nxt_pos;
   logic          dir, nxt_dir;
   logic          nxt_step, nxt_wrap;
   logic [CW-1:0] cnt;
   logic          tick;

   function automatic logic [N-1:0] decode(state_t s, mode_t m, logic [PW-1:0] p);
      logic [N-1:0] one;
      one    = {{(N-1){1'b0}}, 1'b1};
      decode = '0;
      if (s == RUN) begin
         case (m)
            M_CHASE, M_BOUNCE: decode = one << p;
            // shifting past the top bit yields 0, so the subtraction gives all ones at p = N-1
            M_FILL:            decode = ((one << p) << 1) - one;
            default:           decode = '0;
         endcase
      end
   endfunction

   assign tick = bus.en && (cnt == CNT_LAST);
   assign req  = mode_t'(bus.mode);

   always_comb begin
      nxt_state = state;
      nxt_mode  = cur_mode;
      nxt_pos   = pos;
      nxt_dir   = dir;
      nxt_step  = 1'b1;
      nxt_wrap  = 1'b0;
      if (state == BLANK) begin
         if (req == M_OFF) begin
            nxt_step = 1'b0;
         end else begin
            nxt_state = RUN;
            nxt_mode  = req;
            nxt_dir   = 1'b0;
            nxt_pos   = (req == M_FILL) ? '0 : POS_LAST;
         end
      end else if (req != cur_mode) begin
         nxt_state = BLANK;
      end else begin
         case (cur_mode)
            M_CHASE: begin
               nxt_pos  = (pos == '0) ? POS_LAST : pos - PW'(1);
               nxt_wrap = (pos == '0);
            end
            M_FILL: begin
               nxt_pos  = (pos == POS_LAST) ? '0 : pos + PW'(1);
               nxt_wrap = (pos == POS_LAST);
            end
            M_BOUNCE: begin
               if (!dir) begin
                  if (pos == '0) begin
                     nxt_dir = 1'b1;
                     nxt_pos = PW'(1);
                  end else begin
                     nxt_pos = pos - PW'(1);
                  end
               end else begin
                  if (pos == POS_LAST) begin
                     nxt_dir = 1'b0;
                     nxt_pos = POS_LAST - PW'(1);
                  end else begin
                     nxt_pos = pos + PW'(1);
                  end
               end
               nxt_wrap = (nxt_pos == POS_LAST);
            end
            default: nxt_step = 1'b1;
         endcase
      end
   end

   always_ff @(posedge ck) begin
      if (!rs) begin
         cnt      <= '0;
         state    <= BLANK;
         cur_mode <= M_OFF;
         pos      <= '0;
         dir      <= 1'b0;
         bus.led  <= '0;
         bus.step <= 1'b0;
         bus.wrap <= 1'b0;
      end else begin
         bus.step <= 1'b0;
         bus.wrap <= 1'b0;
         if (bus.en) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
         end
         if (tick) begin
            state    <= nxt_state;
            cur_mode <= nxt_mode;
            pos      <= nxt_pos;
            dir      <= nxt_dir;
            bus.led  <= decode(nxt_state, nxt_mode, nxt_pos);
            bus.step <= nxt_step;
            bus.wrap <= nxt_wrap;
         end
      end
   end
endmodule

// File: tb/tb_led_pattern_engine.sv
// Drives four engine instances of differing N/DIV with one shared stimulus stream and
// compares every output, every cycle, against a phase-counting reference model.
module tb_led_pattern_engine;
   logic       ck;
   logic       rs;
   logic       en;
   logic [1:0] mode;

   int checks;
   int failures;

   int nn[4];
   int dd[4];
   int mc[4];
   int ma[4];
   int mk[4];
   logic [31:0] el[4];
   logic        es[4];
   logic        ew[4];
   logic [31:0] ol[4];
   logic        os[4];
   logic        ow[4];
   logic [7:0]  chase_ref[9];

   led_pattern_engine_if #(.N(8)) b0 ();
   led_pattern_engine_if #(.N(4)) b1 ();
   led_pattern_engine_if #(.N(8)) b2 ();
   led_pattern_engine_if #(.N(2)) b3 ();

   assign b0.en = en;  assign b0.mode = mode;
   assign b1.en = en;  assign b1.mode = mode;
   assign b2.en = en;  assign b2.mode = mode;
   assign b3.en = en;  assign b3.mode = mode;

   led_pattern_engine #(.N(8), .DIV(1)) u0 (.ck(ck), .rs(rs), .bus(b0));
   led_pattern_engine #(.N(4), .DIV(1)) u1 (.ck(ck), .rs(rs), .bus(b1));
   led_pattern_engine #(.N(8), .DIV(3)) u2 (.ck(ck), .rs(rs), .bus(b2));
   led_pattern_engine #(.N(2), .DIV(2)) u3 (.ck(ck), .rs(rs), .bus(b3));

   initial begin
      ck = 1'b0;
      forever #5 ck = ~ck;
   end

   // Pattern as a function of animation kind and number of steps taken since it started.
   function automatic logic [31:0] pat(int n, int act, int k);
      int m;
      int p;
      logic [63:0] one;
      one = 64'd1;
      pat = '0;
      case (act)
         1: pat = 32'(one << (n - 1 - (k % n)));
         2: pat = 32'((one << ((k % n) + 1)) - one);
         3: begin
            m   = k % (2 * n - 2);
            p   = (m <= n - 1) ? (n - 1 - m) : (m - (n - 1));
            pat = 32'(one << p);
         end
         default: pat = '0;
      endcase
   endfunction

   task automatic model_update(int i);
      logic t;
      int per;
      es[i] = 1'b0;
      ew[i] = 1'b0;
      if (!rs) begin
         mc[i] = 0;
         ma[i] = 0;
         mk[i] = 0;
      end else if (en) begin
         t     = (mc[i] == dd[i] - 1);
         mc[i] = t ? 0 : mc[i] + 1;
         if (t) begin
            if (ma[i] == 0) begin
               if (mode != 2'b00) begin
                  ma[i] = int'(mode);
                  mk[i] = 0;
                  es[i] = 1'b1;
               end
            end else if (int'(mode) != ma[i]) begin
               ma[i] = 0;
               es[i] = 1'b1;
            end else begin
               per   = (ma[i] == 3) ? 2 * nn[i] - 2 : nn[i];
               mk[i] = mk[i] + 1;
               es[i] = 1'b1;
               ew[i] = ((mk[i] % per) == 0);
            end
         end
      end
      el[i] = pat(nn[i], ma[i], mk[i]);
   endtask

   task automatic cycle();
      @(posedge ck);
      #1;
      for (int i = 0; i < 4; i++) model_update(i);
      ol[0] = 32'(b0.led); os[0] = b0.step; ow[0] = b0.wrap;
      ol[1] = 32'(b1.led); os[1] = b1.step; ow[1] = b1.wrap;
      ol[2] = 32'(b2.led); os[2] = b2.step; ow[2] = b2.wrap;
      ol[3] = 32'(b3.led); os[3] = b3.step; ow[3] = b3.wrap;
      for (int i = 0; i < 4; i++) begin
         checks++;
         assert (ol[i] === el[i]) else begin
            failures++;
            $error("FAIL led inst%0d t=%0t observed=%h expected=%h", i, $time, ol[i], el[i]);
         end
         checks++;
         assert (os[i] === es[i]) else begin
            failures++;
            $error("FAIL step inst%0d t=%0t observed=%b expected=%b", i, $time, os[i], es[i]);
         end
         checks++;
         assert (ow[i] === ew[i]) else begin
            failures++;
            $error("FAIL wrap inst%0d t=%0t observed=%b expected=%b", i, $time, ow[i], ew[i]);
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      nn = '{8, 4, 8, 2};
      dd = '{1, 1, 3, 2};
      for (int i = 0; i < 4; i++) begin
         mc[i] = 0; ma[i] = 0; mk[i] = 0;
      end
      chase_ref = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};

      rs = 1'b0; en = 1'b1; mode = 2'b01;
      cycle();
      cycle();
      checks++;
      assert (b0.led === 8'h00) else begin
         failures++;
         $error("FAIL reset_led observed=%h expected=%h", b0.led, 8'h00);
      end

      // chase from reset with fixed expected sequence on the N=8, DIV=1 instance
      rs = 1'b1;
      for (int j = 0; j < 9; j++) begin
         cycle();
         checks++;
         assert (b0.led === chase_ref[j]) else begin
            failures++;
            $error("FAIL chase_seq%0d observed=%h expected=%h", j, b0.led, chase_ref[j]);
         end
         checks++;
         assert (b0.wrap === (j == 8)) else begin
            failures++;
            $error("FAIL chase_wrap%0d observed=%b expected=%b", j, b0.wrap, (j == 8));
         end
      end
      for (int j = 0; j < 8; j++) cycle();

      // pause mid-step, then mode changes through fill, bounce and off
      en = 1'b0;
      for (int j = 0; j < 5; j++) cycle();
      en = 1'b1;
      for (int j = 0; j < 10; j++) cycle();
      mode = 2'b10;
      for (int j = 0; j < 30; j++) cycle();
      mode = 2'b11;
      for (int j = 0; j < 40; j++) cycle();
      mode = 2'b00;
      for (int j = 0; j < 8; j++) cycle();

      // reset pulse mid-fill
      mode = 2'b10;
      for (int j = 0; j < 13; j++) cycle();
      rs = 1'b0;
      cycle();
      rs = 1'b1;
      for (int j = 0; j < 12; j++) cycle();

      // randomized mode, enable and reset activity
      for (int j = 0; j < 1500; j++) begin
         if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
         en = ($urandom_range(0, 5) != 0);
         rs = ($urandom_range(0, 199) != 0);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
